// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
// Coin handshake between the change dispenser and the coin-ejector actuator.
//   coin_valid : dispenser -> ejector, a coin is requested
//   coin_type  : dispenser -> ejector, 00=500, 01=1000, 10=2000, 11=5000
//   coin_ack   : ejector -> dispenser, the requested coin was accepted
// modport master : dispenser side
// modport slave  : ejector side
// -----------------------------------------------------------------------------
interface change_dispenser_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ack;

  modport master (output coin_valid, output coin_type, input coin_ack);
  modport slave  (input coin_valid, input coin_type, output coin_ack);
endinterface

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Returns change after a sale. On start it latches paid/price and the four
// coin-tube stock counts, computes change = paid - price and pays it out coin
// by coin, greedy largest-denomination-first, limited by the latched stock.
// Each coin goes to the ejector over a valid/ack handshake.
//
// Ports:
//   clk, reset           : clock (rising edge), async active-high reset
//   start                : one-cycle request, honoured only in IDLE
//   paid, price          : amounts sampled on start
//   avail_500..avail_5000: tube stock counts, snapshotted on start
//   coin_if (master)     : coin_valid / coin_type / coin_ack handshake
//   busy                 : state is not IDLE
//   done                 : one-cycle pulse ending every transaction
//   change_error         : exact change not delivered (held until next start)
//   remaining            : change still owed
//   timeout              : ack timeout flag (0 unless CHANGE_TIMEOUT_EN)
//
// Optional feature: define CHANGE_TIMEOUT_EN to abort a coin whose ack does
// not arrive within TIMEOUT_CYCLES cycles of entering ISSUE.
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int AMT_W          = 16,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AMT_W-1:0]     paid,
  input  logic [AMT_W-1:0]     price,
  input  logic [CNT_W-1:0]     avail_500,
  input  logic [CNT_W-1:0]     avail_1000,
  input  logic [CNT_W-1:0]     avail_2000,
  input  logic [CNT_W-1:0]     avail_5000,
  change_dispenser_if.master   coin_if,
  output logic                 busy,
  output logic                 done,
  output logic                 change_error,
  output logic [AMT_W-1:0]     remaining,
  output logic                 timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_DONE, S_FAIL
  } state_t;

  // Coin-type code doubles as the index into the local count array.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] t);
    case (t)
      2'd0:    return AMT_W'(500);
      2'd1:    return AMT_W'(1000);
      2'd2:    return AMT_W'(2000);
      default: return AMT_W'(5000);
    endcase
  endfunction

  state_t           r_state, w_state;
  logic [AMT_W-1:0] r_rem, w_rem;
  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W-1:0] w_cnt [4];
  logic             r_valid, w_valid;
  logic [1:0]       r_type, w_type;
  logic             r_busy;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic             w_found;
  logic [1:0]       w_sel;

`ifdef CHANGE_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] r_tcnt, w_tcnt;
  logic              r_tmo, w_tmo;
`endif

  // Greedy pick: largest denomination that fits and is still in stock.
  always_comb begin
    w_found = 1'b1;
    w_sel   = 2'd0;
    if (r_cnt[3] != '0 && r_rem >= coin_value(2'd3))      w_sel = 2'd3;
    else if (r_cnt[2] != '0 && r_rem >= coin_value(2'd2)) w_sel = 2'd2;
    else if (r_cnt[1] != '0 && r_rem >= coin_value(2'd1)) w_sel = 2'd1;
    else if (r_cnt[0] != '0 && r_rem >= coin_value(2'd0)) w_sel = 2'd0;
    else                                                  w_found = 1'b0;
  end

  always_comb begin
    w_state = r_state;
    w_rem   = r_rem;
    w_cnt   = r_cnt;
    w_valid = r_valid;
    w_type  = r_type;
    w_done  = 1'b0;
    w_err   = r_err;
`ifdef CHANGE_TIMEOUT_EN
    w_tcnt  = r_tcnt;
    w_tmo   = r_tmo;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt[0] = avail_500;
          w_cnt[1] = avail_1000;
          w_cnt[2] = avail_2000;
          w_cnt[3] = avail_5000;
          w_err    = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
          w_tmo    = 1'b0;
`endif
          // Underpayment is caught first so the subtraction never wraps.
          if (paid < price) begin
            w_rem   = '0;
            w_state = S_FAIL;
          end else begin
            w_rem   = paid - price;
            w_state = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (r_rem == '0) begin
          w_state = S_DONE;
        end else if (w_found) begin
          w_valid = 1'b1;
          w_type  = w_sel;
          w_state = S_ISSUE;
`ifdef CHANGE_TIMEOUT_EN
          w_tcnt  = '0;
`endif
        end else begin
          w_state = S_FAIL;
        end
      end
      S_ISSUE: begin
        // Count is non-zero here: the coin was only selected if in stock.
        if (coin_if.coin_ack) begin
          w_rem         = r_rem - coin_value(r_type);
          w_cnt[r_type] = r_cnt[r_type] - 1'b1;
          w_valid       = 1'b0;
          w_state       = S_SELECT;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the coin; remaining still includes its value.
          w_valid = 1'b0;
          w_tmo   = 1'b1;
          w_state = S_FAIL;
        end else begin
          w_tcnt = r_tcnt + 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_err   = 1'b0;
        w_state = S_IDLE;
      end
      S_FAIL: begin
        w_done  = 1'b1;
        w_err   = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_cnt   <= '{default: '0};
      r_valid <= 1'b0;
      r_type  <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
      r_tcnt  <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_rem   <= w_rem;
      r_cnt   <= w_cnt;
      r_valid <= w_valid;
      r_type  <= w_type;
      r_busy  <= (w_state != S_IDLE);
      r_done  <= w_done;
      r_err   <= w_err;
`ifdef CHANGE_TIMEOUT_EN
      r_tcnt  <= w_tcnt;
      r_tmo   <= w_tmo;
`endif
    end
  end

  assign coin_if.coin_valid = r_valid;
  assign coin_if.coin_type  = r_type;
  assign busy               = r_busy;
  assign done               = r_done;
  assign change_error       = r_err;
  assign remaining          = r_rem;
`ifdef CHANGE_TIMEOUT_EN
  assign timeout            = r_tmo;
`else
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int AMT_W = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [AMT_W-1:0] paid = '0, price = '0;
  logic [CNT_W-1:0] a500 = '0, a1000 = '0, a2000 = '0, a5000 = '0;
  logic             busy, done, change_error, timeout;
  logic [AMT_W-1:0] remaining;

  change_dispenser_if cif();

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .start(start), .paid(paid), .price(price),
    .avail_500(a500), .avail_1000(a1000), .avail_2000(a2000), .avail_5000(a5000),
    .coin_if(cif.master), .busy(busy), .done(done), .change_error(change_error),
    .remaining(remaining), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, t0 = 0, done_cnt = 0, done_base = 0, log_base = 0;
  logic ack_en = 1'b0;
  logic [1:0] coin_log [$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  // Ejector model: acks one cycle after it sees a request.
  always @(negedge clk) cif.coin_ack = ack_en && (cif.coin_valid === 1'b1);
  always @(posedge clk) if (cif.coin_valid === 1'b1 && cif.coin_ack === 1'b1) coin_log.push_back(cif.coin_type);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(int p, int pr, int c5, int c10, int c20, int c50);
    @(negedge clk);
    done_base = done_cnt;
    log_base  = coin_log.size();
    paid = AMT_W'(p); price = AMT_W'(pr);
    a500 = CNT_W'(c5); a1000 = CNT_W'(c10); a2000 = CNT_W'(c20); a5000 = CNT_W'(c50);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, output int lat, output int vlat);
    lat = -1; vlat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (vlat < 0 && cif.coin_valid === 1'b1) vlat = cyc - t0;
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) check({tag, "_done_seen"}, 0, 1);
  endtask

  task automatic wait_valid(string tag);
    int seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (cif.coin_valid === 1'b1) seen = 1;
    end
    check({tag, "_valid_seen"}, seen, 1);
  endtask

  task automatic check_coins(string tag, int n, logic [7:0] seq);
    int got_n = coin_log.size() - log_base;
    check({tag, "_ncoins"}, got_n, n);
    for (int i = 0; i < n && i < got_n; i++)
      check($sformatf("%s_coin%0d", tag, i), 32'(coin_log[log_base + i]), 32'(seq[2*i +: 2]));
  endtask

  // One full transaction with the ejector acking; exp_lat/exp_vlat < 0 skip timing.
  task automatic txn(string tag, int p, int pr, int c5, int c10, int c20, int c50,
                     int exp_rem, int exp_err, int n, logic [7:0] seq,
                     int exp_lat, int exp_vlat);
    int lat, vlat;
    ack_en = 1'b1;
    launch(p, pr, c5, c10, c20, c50);
    wait_done(tag, lat, vlat);
    check({tag, "_remaining"}, remaining, exp_rem);
    check({tag, "_change_error"}, change_error, exp_err);
    check({tag, "_busy_after"}, busy, 0);
    if (exp_lat >= 0) check({tag, "_done_latency"}, lat, exp_lat);
    if (exp_vlat >= 0) check({tag, "_valid_latency"}, vlat, exp_vlat);
    @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
    check_coins(tag, n, seq);
  endtask

  initial begin
    int lat, vlat;
    cif.coin_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", cif.coin_valid, 0);
    check("rst_type", cif.coin_type, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", change_error, 0);
    check("rst_rem", remaining, 0);
    check("rst_timeout", timeout, 0);

    // 1500 change: 1000 then 500
    txn("simple", 3000, 1500, 5, 5, 5, 5, 0, 0, 2, 8'b0000_0001, 7, 2);
    // 8500 change: 5000, 2000, 1000, 500
    txn("greedy", 10000, 1500, 5, 5, 5, 5, 0, 0, 4, 8'b0001_1011, -1, -1);
    // One 5000 only: 10000 -> 5000, 2000, 2000, 1000 proves the local count drops
    txn("one5000", 10000, 0, 5, 5, 5, 1, 0, 0, 4, 8'b0110_1011, -1, -1);
    // 1500 owed, no 1000s, two 500s: pays 1000, owes 500
    txn("depleted", 3000, 1500, 2, 0, 5, 5, 500, 1, 2, 8'b0000_0000, -1, -1);
    txn("underpay", 1000, 1500, 5, 5, 5, 5, 0, 1, 0, 8'b0, 2, -1);
    txn("zero", 1500, 1500, 5, 5, 5, 5, 0, 0, 0, 8'b0, 3, -1);
    // 750 owed: one 500 then 250 residue
    txn("odd", 2000, 1250, 5, 5, 5, 5, 250, 1, 1, 8'b0000_0000, -1, -1);

    // start while in ISSUE is ignored and the coin request stays stable
    ack_en = 1'b0;
    launch(3000, 1500, 5, 5, 5, 5);
    wait_valid("holdst");
    check("holdst_type0", cif.coin_type, 1);
    @(negedge clk);
    paid = 16'd10000; price = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("holdst_valid", cif.coin_valid, 1);
    check("holdst_type", cif.coin_type, 1);
    check("holdst_rem", remaining, 1500);
    check("holdst_busy", busy, 1);
    ack_en = 1'b1;
    wait_done("holdst", lat, vlat);
    check("holdst_rem_end", remaining, 0);
    check("holdst_err_end", change_error, 0);
    @(negedge clk);
    check_coins("holdst", 2, 8'b0000_0001);

    // asynchronous reset while a coin is outstanding
    ack_en = 1'b0;
    launch(3000, 1500, 5, 5, 5, 5);
    wait_valid("midrst");
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", cif.coin_valid, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - done_base, 0);
    check("midrst_rem", remaining, 0);

`ifdef CHANGE_TIMEOUT_EN
    ack_en = 1'b0;
    launch(3000, 1500, 5, 5, 5, 5);
    wait_done("tmo", lat, vlat);
    check("tmo_timeout", timeout, 1);
    check("tmo_err", change_error, 1);
    check("tmo_valid", cif.coin_valid, 0);
    check("tmo_rem", remaining, 1500);
    txn("after_tmo", 3000, 1500, 5, 5, 5, 5, 0, 0, 2, 8'b0000_0001, -1, -1);
    check("after_tmo_timeout", timeout, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
